// File: rtl/ipv_pkg.sv
// Shared types and helpers for the multi-channel IPV reducer.
// Count width, output mode and thermometer encoding live here.
package ipv_pkg;

    typedef enum logic {
        IPV_BIN   = 1'b0,
        IPV_THERM = 1'b1
    } ipv_mode_e;

    // Bits needed to hold a ones-count of 0..k.
    function automatic int cw_of(input int k);
        return $clog2(k + 1);
    endfunction

    // MSB-aligned thermometer: bits [k-1 : k-n] set, everything else clear.
    function automatic logic [31:0] therm_encode(input int n, input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < k && i >= k - n) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/ipv_out_fifo.sv
// Synchronous output queue between the reducer and the VOV consumer.
// Pushes are dropped when full and pops when empty; no pass-through.
module ipv_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [NW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == NW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array; contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + NW'(do_push) - NW'(do_pop);
        end
    end

endmodule

// File: rtl/ipv_multi_reducer.sv
// Multi-channel IPV reducer: counts ones per channel over a beat group
// and queues the thermometer or binary encoded result.
module ipv_multi_reducer
    import ipv_pkg::*;
#(
    parameter int K     = 4,
    parameter int C     = 1,
    parameter int DEPTH = 2,
    localparam int CW   = cw_of(K)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CW-1:0]   cfg_len,
    input  logic            cfg_therm,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [C-1:0]    ipv_in,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [C*K-1:0]  vov,
    output logic [CW-1:0]   out_len
);

    localparam int WW = C * K + CW;
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] KL = CW'(K);

    logic [CW-1:0] cnt;
    logic [CW-1:0] len_q;
    logic [CW-1:0] eff_len;
    logic [CW-1:0] cur_len;
    logic [CW-1:0] beat_no;
    ipv_mode_e     therm_q;
    ipv_mode_e     cur_mode;
    logic          start;
    logic          accept;
    logic          done;
    logic          push;
    logic          full;
    logic          empty;
    logic [NW-1:0] occ;
    logic [C*K-1:0] word;
    logic [WW-1:0] head;

    // Config is taken live on the first beat of a group, latched after.
    assign start    = (cnt == '0);
    assign eff_len  = (cfg_len == '0 || cfg_len > KL) ? KL : cfg_len;
    assign cur_len  = start ? eff_len : len_q;
    assign cur_mode = start ? (cfg_therm ? IPV_THERM : IPV_BIN) : therm_q;
    assign beat_no  = cnt + 1'b1;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign done     = (beat_no == cur_len) || in_last;
    assign push     = accept && done;

    // Beat counter and per-group configuration latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            len_q   <= KL;
            therm_q <= IPV_THERM;
        end else if (accept) begin
            if (start) begin
                len_q   <= eff_len;
                therm_q <= cur_mode;
            end
            cnt <= done ? '0 : beat_no;
        end
    end

    for (genvar c = 0; c < C; c++) begin : g_ch
        logic [CW-1:0] acc;
        logic [CW-1:0] acc_nxt;
        logic [K-1:0]  th;

        assign acc_nxt = (start ? '0 : acc) + CW'(ipv_in[c]);
        assign th      = K'(therm_encode(int'(acc_nxt), K));
        assign word[c*K +: K] = (cur_mode == IPV_THERM) ? th : K'(acc_nxt);

        // Running ones-count for this channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (accept) begin
                acc <= acc_nxt;
            end
        end
    end

    ipv_out_fifo #(
        .W     (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({word, beat_no}),
        .pop   (out_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    assign out_valid      = (occ != '0);
    assign {vov, out_len} = empty ? '0 : head;

endmodule

// File: tb/tb_ipv_multi_reducer.sv
// Bench for ipv_multi_reducer with K=4, C=2, DEPTH=2.
// Directed group table, queue/reset sequences, then random vs model.
module tb_ipv_multi_reducer;

    localparam int K     = 4;
    localparam int C     = 2;
    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] cfg_len;
    logic       cfg_therm;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ipv_in;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] vov;
    logic [2:0] out_len;

    ipv_multi_reducer #(
        .K     (K),
        .C     (C),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .cfg_therm (cfg_therm),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ipv_in    (ipv_in),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vov       (vov),
        .out_len   (out_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed group records; beat b drives bits[2b+1:2b] = {ch1, ch0}.
    typedef struct {
        logic [2:0] len;
        logic       therm;
        int         nb;
        int         last_idx;
        logic [7:0] bits;
        logic [7:0] vov;
        logic [2:0] olen;
    } vec_t;

    vec_t tv [8];

    // Reference model: collect a group, count ones, encode arithmetically.
    logic [10:0] exp_q [$];
    bit          m_active;
    int          m_len;
    bit          m_therm;
    int          m_beats;
    int          m_ones [C];

    function automatic logic [3:0] enc(input int n, input bit th);
        int v;
        if (th) v = ((1 << n) - 1) << (K - n);
        else    v = n;
        return 4'(v);
    endfunction

    task automatic model_beat(input logic [2:0] l, input logic th,
                              input logic [1:0] bits, input logic last);
        logic [7:0] w;
        if (!m_active) begin
            m_active = 1'b1;
            m_len    = (l == 0 || l > K) ? K : int'(l);
            m_therm  = th;
            m_beats  = 0;
            for (int c = 0; c < C; c++) m_ones[c] = 0;
        end
        for (int c = 0; c < C; c++) m_ones[c] += int'(bits[c]);
        m_beats++;
        if (m_beats == m_len || last) begin
            for (int c = 0; c < C; c++) w[c*K +: K] = enc(m_ones[c], m_therm);
            exp_q.push_back({w, 3'(m_beats)});
            m_active = 1'b0;
        end
    endtask

    initial begin
        tv[0] = '{3'd0, 1'b1, 4, -1, 8'h51, 8'h0E, 3'd4};
        tv[1] = '{3'd3, 1'b0, 3, -1, 8'h1D, 8'h13, 3'd3};
        tv[2] = '{3'd0, 1'b1, 2,  1, 8'h07, 8'h8C, 3'd2};
        tv[3] = '{3'd1, 1'b1, 1, -1, 8'h03, 8'h88, 3'd1};
        tv[4] = '{3'd7, 1'b0, 4, -1, 8'hEF, 8'h43, 3'd4};
        tv[5] = '{3'd2, 1'b1, 2, -1, 8'h00, 8'h00, 3'd2};
        tv[6] = '{3'd4, 1'b1, 4, -1, 8'hFF, 8'hFF, 3'd4};
        tv[7] = '{3'd3, 1'b0, 1,  0, 8'h02, 8'h10, 3'd1};

        rst_n     = 1'b0;
        cfg_len   = '0;
        cfg_therm = 1'b0;
        in_valid  = 1'b0;
        ipv_in    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_active  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_vov", vov, 0);
        chk("rst_out_len", out_len, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed groups; cfg is scrambled after the first beat.
        for (int r = 0; r < 8; r++) begin
            out_ready = 1'b0;
            chk($sformatf("tv%0d_ready", r), in_ready, 1);
            for (int b = 0; b < tv[r].nb; b++) begin
                in_valid  = 1'b1;
                ipv_in    = tv[r].bits[2*b +: 2];
                in_last   = (b == tv[r].last_idx);
                cfg_len   = (b == 0) ? tv[r].len : 3'd1;
                cfg_therm = (b == 0) ? tv[r].therm : ~tv[r].therm;
                tick();
                if (b < tv[r].nb - 1)
                    chk($sformatf("tv%0d_b%0d_idle", r, b), out_valid, 0);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk($sformatf("tv%0d_valid", r), out_valid, 1);
            chk($sformatf("tv%0d_vov", r), vov, tv[r].vov);
            chk($sformatf("tv%0d_len", r), out_len, tv[r].olen);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("tv%0d_popped", r), out_valid, 0);
        end

        // Queue fill with length-1 groups, then drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cfg_len   = 3'd1;
        cfg_therm = 1'b1;
        ipv_in    = 2'b01;
        tick();
        chk("q_ready1", in_ready, 1);
        chk("q_head1", vov, 8'h08);
        ipv_in = 2'b10;
        tick();
        chk("q_full", in_ready, 0);
        ipv_in = 2'b11;
        tick();
        chk("q_hold1", in_ready, 0);
        tick();
        chk("q_hold2", in_ready, 0);
        chk("q_head_stable", vov, 8'h08);
        chk("q_len", out_len, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("q_ready_back", in_ready, 1);
        chk("q_valid2", out_valid, 1);
        chk("q_head2", vov, 8'h80);
        tick();
        chk("q_drained", out_valid, 0);
        out_ready = 1'b0;

        // Reset with a queued word and a half-done group.
        in_valid  = 1'b1;
        cfg_len   = 3'd1;
        cfg_therm = 1'b1;
        ipv_in    = 2'b01;
        tick();
        cfg_len = 3'd0;
        ipv_in  = 2'b11;
        tick();
        tick();
        in_valid = 1'b0;
        chk("rq_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rq_out_valid", out_valid, 0);
        chk("rq_vov", vov, 0);
        chk("rq_len", out_len, 0);
        chk("rq_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_valid  = 1'b1;
        cfg_len   = 3'd0;
        cfg_therm = 1'b1;
        ipv_in    = 2'b11;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("rq_new_valid", out_valid, 1);
        chk("rq_new_vov", vov, 8'hFF);
        chk("rq_new_len", out_len, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit acc_now;
            bit pop_now;
            chk("rnd_ready", in_ready, exp_q.size() < DEPTH);
            chk("rnd_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) chk("rnd_word", {vov, out_len}, exp_q[0]);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            cfg_len   = 3'($urandom_range(7));
            cfg_therm = 1'($urandom_range(1));
            ipv_in    = 2'($urandom_range(3));
            in_last   = ($urandom_range(5) == 0);
            acc_now   = in_valid && (exp_q.size() < DEPTH);
            pop_now   = out_ready && (exp_q.size() > 0);
            tick();
            if (pop_now) void'(exp_q.pop_front());
            if (acc_now) model_beat(cfg_len, cfg_therm, ipv_in, in_last);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
